// File: rtl/uart_tx_arb.sv
// Round-robin arbiter that locks a UART transmitter to one requester for a whole packet.
// The lock is released on the last byte or after TIMEOUT idle cycles from the owner.
module uart_tx_arb #(
    parameter int NREQ    = 4,
    parameter int DLEN    = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NREQ-1:0]      i_req_valid,
    output logic [NREQ-1:0]      o_req_ready,
    input  logic [NREQ*DLEN-1:0] i_req_data,
    input  logic [NREQ-1:0]      i_req_last,
    output logic                 o_tx_valid,
    input  logic                 i_tx_ready,
    output logic [DLEN-1:0]      o_tx_data,
    output logic [NREQ-1:0]      o_grant,
    output logic                 o_timeout
);

    // state | meaning
    // IDLE  | no owner; arbitrate among valid requesters
    // LOCK  | grant_q owns the transmitter until last byte or idle timeout
    typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TIMEOUT);

    state_t          state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [IW-1:0]   gidx_q, gidx_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   win_idx, next_ptr;
    logic [IW:0]     cand;
    logic            win_found;
    logic            sel_valid, sel_last, rel;
    logic [DLEN-1:0] sel_data;

    // Search upward from ptr_q with wrap; first valid port wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = {1'b0, ptr_q} + (IW+1)'(i);
            if (cand >= (IW+1)'(NREQ)) cand = cand - (IW+1)'(NREQ);
            if (!win_found && i_req_valid[cand[IW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IW-1:0];
            end
        end
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (grant_q[k]) begin
                sel_valid = i_req_valid[k];
                sel_last  = i_req_last[k];
                sel_data  = i_req_data[k*DLEN +: DLEN];
            end
        end
    end

    assign next_ptr = (gidx_q == IW'(NREQ-1)) ? '0 : gidx_q + IW'(1);
    assign o_grant  = grant_q;

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        gidx_d      = gidx_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        rel         = 1'b0;
        o_tx_valid  = 1'b0;
        o_tx_data   = sel_data;
        o_req_ready = '0;
        o_timeout   = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (win_found) begin
                    state_d = LOCK;
                    grant_d = NREQ'(1) << win_idx;
                    gidx_d  = win_idx;
                end
            end
            LOCK: begin
                o_tx_valid  = sel_valid;
                o_req_ready = grant_q & {NREQ{i_tx_ready}};
                // Backpressure with the owner still valid never counts as idle.
                if (sel_valid) begin
                    cnt_d = '0;
                    if (i_tx_ready && sel_last) rel = 1'b1;
                end else if (cnt_q == CW'(TIMEOUT-1)) begin
                    o_timeout = 1'b1;
                    rel       = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
                if (rel) begin
                    state_d = IDLE;
                    grant_d = '0;
                    cnt_d   = '0;
                    ptr_d   = next_ptr;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: packet-level owner/ptr model checked every cycle,
// plus directed scenarios with hand-computed byte/grant orders.
module tb_uart_tx_arb;
    localparam int NREQ = 4, DLEN = 8, TIMEOUT = 16;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic [3:0]      i_req_valid, o_req_ready, i_req_last, o_grant;
    logic [31:0]     i_req_data;
    logic            o_tx_valid, i_tx_ready, o_timeout;
    logic [7:0]      o_tx_data;

    always #5 clk = ~clk;

    uart_tx_arb #(.NREQ(NREQ), .DLEN(DLEN), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rstn(rstn),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_data(i_req_data), .i_req_last(i_req_last),
        .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready), .o_tx_data(o_tx_data),
        .o_grant(o_grant), .o_timeout(o_timeout)
    );

    int checks = 0, failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    // Requester sources: each port replays its queue of {last,data}.
    logic [8:0] pq[4][$];
    initial begin
        logic [3:0] acc;
        logic [8:0] e;
        i_req_valid = '0;
        i_req_data  = '0;
        i_req_last  = '0;
        forever begin
            @(posedge clk);
            acc = o_req_ready & i_req_valid;
            for (int k = 0; k < NREQ; k++)
                if (rstn && acc[k] && pq[k].size() > 0) void'(pq[k].pop_front());
            #1;
            for (int k = 0; k < NREQ; k++) begin
                if (pq[k].size() > 0) begin
                    e = pq[k][0];
                    i_req_valid[k]         = 1'b1;
                    i_req_data[k*8 +: 8]   = e[7:0];
                    i_req_last[k]          = e[8];
                end else begin
                    i_req_valid[k]         = 1'b0;
                    i_req_data[k*8 +: 8]   = 8'h00;
                    i_req_last[k]          = 1'b0;
                end
            end
        end
    end

    // Packet-level model: who owns the link, where the rotation resumes, idle run length.
    int m_owner = -1, m_ptr = 0, m_idle = 0, cyc = 0;
    int acc_log[$], acc_cyc[$], grant_log[$], to_cyc[$];
    bit started = 0;

    always @(posedge clk) begin
        int p;
        started = 1;
        if (!rstn) begin
            m_owner = -1; m_ptr = 0; m_idle = 0;
        end else if (m_owner < 0) begin
            m_idle = 0;
            for (int i = 0; i < NREQ; i++) begin
                p = (m_ptr + i) % NREQ;
                if (m_owner < 0 && i_req_valid[p]) m_owner = p;
            end
            if (m_owner >= 0) grant_log.push_back(m_owner);
        end else if (i_req_valid[m_owner]) begin
            m_idle = 0;
            if (i_tx_ready) begin
                acc_log.push_back(m_owner * 256 + int'(i_req_data[m_owner*8 +: 8]));
                acc_cyc.push_back(cyc);
                if (i_req_last[m_owner]) begin
                    m_ptr = (m_owner + 1) % NREQ;
                    m_owner = -1;
                end
            end
        end else if (m_idle == TIMEOUT - 1) begin
            to_cyc.push_back(cyc);
            m_ptr = (m_owner + 1) % NREQ;
            m_owner = -1;
            m_idle = 0;
        end else begin
            m_idle++;
        end
        cyc++;
    end

    int dut_to_cnt = 0, dut_to_cyc = -1;
    always @(negedge clk) begin
        logic [3:0] eg, er;
        logic       ev, et;
        if (started) begin
            eg = (m_owner < 0) ? 4'b0 : 4'(1 << m_owner);
            ev = (m_owner < 0) ? 1'b0 : i_req_valid[m_owner];
            er = (m_owner >= 0 && i_tx_ready) ? eg : 4'b0;
            et = (m_owner >= 0) && !i_req_valid[m_owner] && (m_idle == TIMEOUT - 1);
            chk("grant", 64'(o_grant), 64'(eg));
            chk("tx_valid", 64'(o_tx_valid), 64'(ev));
            chk("req_ready", 64'(o_req_ready), 64'(er));
            chk("timeout", 64'(o_timeout), 64'(et));
            if (ev) chk("tx_data", 64'(o_tx_data), 64'(i_req_data[m_owner*8 +: 8]));
            if (o_timeout === 1'b1) begin
                dut_to_cnt++;
                dut_to_cyc = cyc;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        acc_log.delete(); acc_cyc.delete(); grant_log.delete(); to_cyc.delete();
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        for (int k = 0; k < NREQ; k++) pq[k].delete();
        tick(3);
        rstn = 1'b1;
        clear_logs();
    endtask

    function automatic bit busy();
        return (m_owner >= 0) || pq[0].size() > 0 || pq[1].size() > 0 ||
               pq[2].size() > 0 || pq[3].size() > 0;
    endfunction

    task automatic wait_done(input string name, input int max);
        int n = 0;
        while (busy() && n < max) begin
            tick(1);
            n++;
        end
        chk({name, "_completes"}, 64'(n < max), 64'd1);
    endtask

    initial begin
        int c, n;
        i_tx_ready = 1'b0;
        tick(1);

        // Two ports valid together, 1-byte packets
        do_reset();
        i_tx_ready = 1'b1;
        chk("rst_grant", 64'(o_grant), 64'd0);
        chk("rst_tx_valid", 64'(o_tx_valid), 64'd0);
        chk("rst_req_ready", 64'(o_req_ready), 64'd0);
        pq[1].push_back(9'h141);
        pq[2].push_back(9'h142);
        wait_done("t1", 20);
        chk("t1_nbytes", 64'(acc_log.size()), 64'd2);
        chk("t1_byte0", 64'(qget(acc_log, 0)), 64'h141);
        chk("t1_byte1", 64'(qget(acc_log, 1)), 64'h242);
        chk("t1_grant0", 64'(qget(grant_log, 0)), 64'd1);
        chk("t1_grant1", 64'(qget(grant_log, 1)), 64'd2);
        chk("t1_gap", 64'(qget(acc_cyc, 1) - qget(acc_cyc, 0)), 64'd2);

        // Multi-byte packet holds off a competing port
        do_reset();
        i_tx_ready = 1'b1;
        pq[0].push_back(9'h010); pq[0].push_back(9'h011); pq[0].push_back(9'h112);
        pq[3].push_back(9'h130);
        wait_done("t2", 30);
        chk("t2_byte0", 64'(qget(acc_log, 0)), 64'h010);
        chk("t2_byte1", 64'(qget(acc_log, 1)), 64'h011);
        chk("t2_byte2", 64'(qget(acc_log, 2)), 64'h012);
        chk("t2_byte3", 64'(qget(acc_log, 3)), 64'h330);
        chk("t2_burst", 64'(qget(acc_cyc, 2) - qget(acc_cyc, 0)), 64'd2);
        chk("t2_grants", 64'(grant_log.size()), 64'd2);
        chk("t2_grant1", 64'(qget(grant_log, 1)), 64'd3);

        // All ports busy: strict rotation
        do_reset();
        i_tx_ready = 1'b1;
        for (int k = 0; k < NREQ; k++)
            for (int j = 0; j < 3; j++) pq[k].push_back(9'(9'h100 | (k << 4) | j));
        wait_done("t3", 200);
        for (int i = 0; i < 12; i++) begin
            chk("t3_grant", 64'(qget(grant_log, i)), 64'(i % 4));
            chk("t3_byte", 64'(qget(acc_log, i)), 64'((i % 4) * 256 + (i % 4) * 16 + i / 4));
        end

        // Owner goes silent mid-packet: forced release after TIMEOUT cycles
        do_reset();
        i_tx_ready = 1'b1;
        pq[2].push_back(9'h055);
        wait_done("t4", 60);
        chk("t4_grant0", 64'(qget(grant_log, 0)), 64'd2);
        chk("t4_byte", 64'(qget(acc_log, 0)), 64'h255);
        chk("t4_model_to", 64'(qget(to_cyc, 0) - qget(acc_cyc, 0)), 64'd16);
        chk("t4_dut_to", 64'(dut_to_cyc - qget(acc_cyc, 0)), 64'd16);
        chk("t4_idle_grant", 64'(o_grant), 64'd0);
        pq[0].push_back(9'h101);
        pq[3].push_back(9'h133);
        wait_done("t4b", 20);
        chk("t4_ptr_grant", 64'(qget(grant_log, 1)), 64'd3);
        chk("t4_next_grant", 64'(qget(grant_log, 2)), 64'd0);

        // Long backpressure is not idleness
        do_reset();
        dut_to_cnt = 0;
        i_tx_ready = 1'b0;
        pq[0].push_back(9'h177);
        tick(5000);
        chk("t5_no_timeout", 64'(dut_to_cnt), 64'd0);
        chk("t5_no_accept", 64'(acc_log.size()), 64'd0);
        chk("t5_valid_held", 64'(o_tx_valid), 64'd1);
        chk("t5_data_held", 64'(o_tx_data), 64'h77);
        i_tx_ready = 1'b1;
        c = cyc;
        wait_done("t5", 10);
        chk("t5_accept_cyc", 64'(qget(acc_cyc, 0)), 64'(c));
        chk("t5_byte", 64'(qget(acc_log, 0)), 64'h077);

        // Reset in the middle of a 4-byte packet
        do_reset();
        i_tx_ready = 1'b1;
        pq[0].push_back(9'h0A0); pq[0].push_back(9'h0A1);
        pq[0].push_back(9'h0A2); pq[0].push_back(9'h1A3);
        n = 0;
        while (acc_log.size() < 2 && n < 20) begin
            tick(1);
            n++;
        end
        chk("t6_two_bytes_seen", 64'(n < 20), 64'd1);
        rstn = 1'b0;
        i_tx_ready = 1'b0;
        tick(1);
        chk("t6_rst_grant", 64'(o_grant), 64'd0);
        chk("t6_rst_valid", 64'(o_tx_valid), 64'd0);
        chk("t6_no_more_bytes", 64'(acc_log.size()), 64'd2);
        for (int k = 0; k < NREQ; k++) pq[k].delete();
        pq[2].push_back(9'h1C0);
        pq[0].push_back(9'h1B0);
        tick(1);
        clear_logs();
        rstn = 1'b1;
        i_tx_ready = 1'b1;
        wait_done("t6", 20);
        chk("t6_fresh_grant", 64'(qget(grant_log, 0)), 64'd0);
        chk("t6_byte0", 64'(qget(acc_log, 0)), 64'h0B0);
        chk("t6_byte1", 64'(qget(acc_log, 1)), 64'h2C0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
